nios_system_input_pio: RTL and testbench
========================================

NIOS_SYSTEM_INPUT_PIO -- requirements
Module: nios_system_input_pio

Interface
REQ-001 Parameter WIDTH, default 4: number of input pins, legal range 1..32.
REQ-002 Parameter EDGE_TYPE, default 0: edge that sets the capture bit; 0 = rising, 1 = falling, 2 = any.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth, legal range 2..3.
REQ-004 clk  input  1  system clock; every flop in the block is rising-edge on clk.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 address  input  2  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 read_n  input  1  read strobe, active-low.
REQ-009 write_n  input  1  write strobe, active-low.
REQ-010 writedata  input  32  write data.
REQ-011 in_port  input  WIDTH  asynchronous external pins (keys, switches).
REQ-012 readdata  output  32  registered read data.
REQ-013 irq  output  1  level interrupt, active-high.

Function
REQ-014 in_port SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is sync_in. All logic SHALL use sync_in only.
REQ-015 A delayed copy sync_d SHALL be kept. Edge detection: rising = sync_in & ~sync_d; falling = ~sync_in & sync_d; any = XOR of the two.
REQ-016 Register map: 0 = DATA (RO, sync_in); 1 = reserved (reads 0, writes ignored); 2 = IRQ_MASK (RW, WIDTH bits); 3 = EDGE_CAPTURE (RW1C, WIDTH bits).
REQ-017 Read access: chipselect & ~read_n SHALL load readdata on the next clk edge.
  - Latency: 1 cycle.
  - Bits 31:WIDTH zero-filled.
  - readdata holds its value when no read is active.
REQ-018 A write is chipselect & ~write_n.
  - Address 2: loads writedata[WIDTH-1:0] into IRQ_MASK.
  - Address 3: clears every EDGE_CAPTURE bit whose writedata bit is 1.
REQ-019 A detected edge SHALL set its EDGE_CAPTURE bit, which stays set until cleared by write.
REQ-020 If an edge is detected and a write-1-clear hits the same bit in the same cycle, set SHALL win; the bit remains 1.
REQ-021 irq SHALL be registered as |(EDGE_CAPTURE & IRQ_MASK).
  - irq asserts 1 cycle after the capture bit sets.
  - irq deasserts 1 cycle after the bit clears or its mask bit drops.
REQ-022 Total latency from an in_port transition to the EDGE_CAPTURE bit setting: SYNC_STAGES+1 cycles. irq follows one cycle later.
REQ-023 Simultaneous read and write to the same address: readdata returns the pre-write value.
REQ-024 Pulses shorter than one clk period need not be captured. Any level held for at least 2 cycles SHALL be captured.

Reset
REQ-025 Reset forces the following to zero, immediately and asynchronously:
  - synchronizer chain and sync_d;
  - IRQ_MASK and EDGE_CAPTURE;
  - readdata and irq.
REQ-026 A reset mid-operation SHALL discard pending captures. After release, an input already high SHALL NOT register a rising edge until it first goes low and then high again.

Configuration
REQ-027 Macro NIOS_SYSTEM_INPUT_PIO_IRQ_EN.
  - Defined: IRQ_MASK, EDGE_CAPTURE and irq are implemented as specified above.
  - Undefined: no capture or mask flops are built; addresses 2 and 3 read 0 and ignore writes; irq is tied to 0; the DATA path is unchanged.

Structure
REQ-028 A shared package nios_system_pio_pkg SHALL hold:
  - register address constants (ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3);
  - EDGE_TYPE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY).
REQ-029 Sub-module nios_system_pio_sync SHALL implement the parameterized synchronizer plus edge detector (outputs sync_in and edge). The top level instantiates it once.

Verification
REQ-030 Reset, then read address 0 with in_port=4'b1010 held for 5 cycles -> readdata=32'h0000000A one cycle after the read strobe; irq=0.
REQ-031 EDGE_TYPE=0, mask=4'b0001, rising edge on in_port[0] -> EDGE_CAPTURE=4'b0001 after 3 cycles and irq=1 one cycle later; writing 32'h1 to address 3 -> irq=0 one cycle after the write.
REQ-032 Mask=0 and edges on all pins -> address 3 reads 32'h0000000F and irq stays 0; writing mask=4'b0100 -> irq=1 within 1 cycle.
REQ-033 Clear write of 32'hF in the same cycle as a new edge on bit 2 is detected -> EDGE_CAPTURE=4'b0100 and irq stays 1 (if masked).
REQ-034 in_port[3] held high through reset release -> EDGE_CAPTURE=0; then a low/high toggle -> bit 3 sets.
REQ-035 Build without NIOS_SYSTEM_INPUT_PIO_IRQ_EN, edges on all pins -> address 3 reads 0, irq stays 0, DATA reads remain correct.

Source files
------------

// File: rtl/nios_system_pio_pkg.sv
// Shared constants for the Nios system input PIO.
//   - Avalon-MM word addresses of the PIO register map
//   - EDGE_TYPE encodings understood by the edge detector
package nios_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_system_pio_sync.sv
// Input synchronizer and edge detector for the input PIO.
// Ports:
//   clk      - system clock (rising edge)
//   reset_n  - asynchronous active-low reset
//   in_port  - asynchronous external pins
//   sync_in  - last stage of the SYNC_STAGES-deep synchronizer
//   edges    - one-cycle pulse per bit when the selected edge is seen on sync_in
// Edges are suppressed until sync_d holds a genuinely sampled value, so a
// pin already high when reset releases does not look like a rising edge.
module nios_system_pio_sync
  import nios_system_pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edges
);

  logic [WIDTH-1:0]     chain_r [SYNC_STAGES];
  logic [WIDTH-1:0]     sync_d_r;
  logic [SYNC_STAGES:0] primed_r;
  logic [WIDTH-1:0]     raw_edge_s;

  // Synchronizer chain, delayed copy and priming shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        chain_r[i] <= {WIDTH{1'b0}};
      end
      sync_d_r <= {WIDTH{1'b0}};
      primed_r <= {(SYNC_STAGES+1){1'b0}};
    end else begin
      chain_r[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain_r[i] <= chain_r[i-1];
      end
      sync_d_r <= chain_r[SYNC_STAGES-1];
      // primed_r[SYNC_STAGES] rises once sync_d_r carries a real sample
      primed_r <= {primed_r[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sync_in = chain_r[SYNC_STAGES-1];

  // Edge selection by EDGE_TYPE
  always_comb begin
    raw_edge_s = {WIDTH{1'b0}};
    case (EDGE_TYPE)
      EDGE_RISE: raw_edge_s = sync_in & ~sync_d_r;
      EDGE_FALL: raw_edge_s = ~sync_in & sync_d_r;
      default:   raw_edge_s = sync_in ^ sync_d_r;
    endcase
  end

  // Edge qualification after reset
  always_comb begin
    if (primed_r[SYNC_STAGES]) begin
      edges = raw_edge_s;
    end else begin
      edges = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/nios_system_input_pio.sv
// Avalon-MM input PIO with optional edge-capture interrupt.
// Ports:
//   clk, reset_n                   - clock and asynchronous active-low reset
//   address, chipselect, read_n,
//   write_n, writedata             - Avalon-MM slave (word addressed)
//   in_port                        - asynchronous external pins
//   readdata                       - registered read data, 1-cycle latency
//   irq                            - registered level interrupt
// Register map: 0 DATA (RO), 1 reserved, 2 IRQ_MASK (RW), 3 EDGE_CAPTURE (RW1C).
// Build macro NIOS_SYSTEM_INPUT_PIO_IRQ_EN enables the mask, capture and irq
// logic; without it addresses 2/3 read 0, writes are ignored and irq is 0.
module nios_system_input_pio
  import nios_system_pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] mask_s;
  logic [WIDTH-1:0] capture_s;
  logic             rd_en_s;
  logic [31:0]      rd_value_s;
  logic [31:0]      readdata_r;

  nios_system_pio_sync #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .sync_in (sync_in),
    .edges   (edges)
  );

  assign rd_en_s = chipselect & ~read_n;

`ifdef NIOS_SYSTEM_INPUT_PIO_IRQ_EN
  logic             wr_en_s;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] capture_r;
  logic [WIDTH-1:0] clear_s;
  logic             irq_r;
  logic             unused_wdata;

  assign wr_en_s      = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // Write-1-clear pattern for the capture register
  always_comb begin
    if (wr_en_s && (address == ADDR_EDGE)) begin
      clear_s = writedata[WIDTH-1:0];
    end else begin
      clear_s = {WIDTH{1'b0}};
    end
  end

  // Interrupt mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r <= {WIDTH{1'b0}};
    end else if (wr_en_s && (address == ADDR_MASK)) begin
      mask_r <= writedata[WIDTH-1:0];
    end else begin
      mask_r <= mask_r;
    end
  end

  // Edge capture: a new edge wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture_r <= {WIDTH{1'b0}};
    end else begin
      capture_r <= (capture_r & ~clear_s) | edges;
    end
  end

  // Registered interrupt from masked capture bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |(capture_r & mask_r);
    end
  end

  assign mask_s    = mask_r;
  assign capture_s = capture_r;
  assign irq       = irq_r;
`else
  logic unused_bus;

  assign unused_bus = ^{writedata, write_n, edges};
  assign mask_s     = {WIDTH{1'b0}};
  assign capture_s  = {WIDTH{1'b0}};
  assign irq        = 1'b0;
`endif

  // Read multiplexer, upper bits zero-filled
  always_comb begin
    rd_value_s = 32'h0000_0000;
    case (address)
      ADDR_DATA: rd_value_s[WIDTH-1:0] = sync_in;
      ADDR_MASK: rd_value_s[WIDTH-1:0] = mask_s;
      ADDR_EDGE: rd_value_s[WIDTH-1:0] = capture_s;
      default:   rd_value_s = 32'h0000_0000;
    endcase
  end

  // Read data register: samples pre-write state, holds when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 32'h0000_0000;
    end else if (rd_en_s) begin
      readdata_r <= rd_value_s;
    end else begin
      readdata_r <= readdata_r;
    end
  end

  assign readdata = readdata_r;

endmodule

// File: tb/tb_nios_system_input_pio.sv
// Self-checking bench for nios_system_input_pio (default parameters).
// A delay-line reference model derives expected readdata/irq every cycle;
// directed sequences add literal expectations.
module tb_nios_system_input_pio;
  import nios_system_pio_pkg::*;

  localparam int WIDTH = 4;
  localparam int ETYPE = 0;
  localparam int S     = 2;
`ifdef NIOS_SYSTEM_INPUT_PIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [31:0] EN_MASK = IRQ_EN ? 32'hFFFF_FFFF : 32'h0000_0000;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       address = 2'd0;
  logic             chipselect = 1'b0;
  logic             read_n = 1'b1;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = 32'd0;
  logic [WIDTH-1:0] in_port = 4'b0000;
  logic [31:0]      readdata;
  logic             irq;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  nios_system_input_pio #(.WIDTH(WIDTH), .EDGE_TYPE(ETYPE), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(readdata), .irq(irq)
  );

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] hist[$];
  logic [31:0]      m_readdata = 32'd0;
  logic             m_irq = 1'b0;
  logic [WIDTH-1:0] m_mask = 4'b0000;
  logic [WIDTH-1:0] m_cap  = 4'b0000;

  // In-port value seen at edge k (1-based since reset release), 0 before that
  function automatic logic [WIDTH-1:0] sample_at(int k);
    if (k < 1 || k > hist.size()) return 4'b0000;
    return hist[k-1];
  endfunction

  task automatic model_step();
    int n;
    logic [WIDTH-1:0] si, sd, ev, clr;
    logic [31:0] rv;
    n  = hist.size();
    si = sample_at(n - S + 1);
    sd = sample_at(n - S);
    ev = 4'b0000;
    if (n - S >= 1) begin
      case (ETYPE)
        0:       ev = si & ~sd;
        1:       ev = ~si & sd;
        default: ev = si ^ sd;
      endcase
    end
    rv = 32'd0;
    case (address)
      2'd0:    rv = {28'd0, si};
      2'd2:    rv = {28'd0, m_mask} & EN_MASK;
      2'd3:    rv = {28'd0, m_cap} & EN_MASK;
      default: rv = 32'd0;
    endcase
    if (chipselect && !read_n) m_readdata = rv;
    m_irq = IRQ_EN && (|(m_cap & m_mask));
    clr = 4'b0000;
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[WIDTH-1:0];
    if (chipselect && !write_n && address == 2'd3) clr = writedata[WIDTH-1:0];
    m_cap = (m_cap & ~clr) | ev;
    hist.push_back(in_port);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist.delete();
      m_readdata = 32'd0;
      m_irq = 1'b0;
      m_mask = 4'b0000;
      m_cap = 4'b0000;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    checks++;
    if (readdata !== m_readdata) begin
      fails++;
      $display("FAIL model_readdata t=%0t got=%h want=%h", $time, readdata, m_readdata);
    end
    checks++;
    if (irq !== m_irq) begin
      fails++;
      $display("FAIL model_irq t=%0t got=%b want=%b", $time, irq, m_irq);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    // Reset state and DATA read
    in_port = 4'b1010;
    wait_cycles(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    wait_cycles(5);
    bus_read(ADDR_DATA, rd);
    check("data_1010", rd, 32'h0000_000A);
    check("data_irq0", {31'd0, irq}, 32'h0);
    bus_read(ADDR_EDGE, rd);
    check("no_capture_after_reset", rd, 32'h0);

    // Single rising edge with mask bit 0
    in_port = 4'b0000;
    wait_cycles(4);
    bus_write(ADDR_MASK, 32'h1);
    in_port = 4'b0001;
    wait_cycles(3);
    check("irq_not_early", {31'd0, irq}, 32'h0);
    wait_cycles(1);
    check("irq_after_capture", {31'd0, irq}, {31'd0, IRQ_EN});
    bus_write(ADDR_EDGE, 32'h1);
    check("irq_during_clear", {31'd0, irq}, {31'd0, IRQ_EN});
    wait_cycles(1);
    check("irq_cleared", {31'd0, irq}, 32'h0);

    // Edges on all pins with mask 0, then unmask bit 2
    bus_write(ADDR_MASK, 32'h0);
    in_port = 4'b0000;
    wait_cycles(4);
    in_port = 4'b1111;
    wait_cycles(5);
    bus_read(ADDR_EDGE, rd);
    check("capture_all", rd, 32'h0000_000F & EN_MASK);
    check("masked_irq0", {31'd0, irq}, 32'h0);
    bus_read(ADDR_DATA, rd);
    check("data_1111", rd, 32'h0000_000F);
    bus_write(ADDR_MASK, 32'h4);
    wait_cycles(1);
    check("irq_unmask", {31'd0, irq}, {31'd0, IRQ_EN});
    bus_read(ADDR_MASK, rd);
    check("mask_read", rd, 32'h0000_0004 & EN_MASK);

    // Clear-all colliding with a new edge on bit 2
    in_port = 4'b1011;
    wait_cycles(4);
    in_port = 4'b1111;
    wait_cycles(2);
    bus_write(ADDR_EDGE, 32'hF);
    bus_read(ADDR_EDGE, rd);
    check("set_wins_clear", rd, 32'h0000_0004 & EN_MASK);
    check("irq_stays", {31'd0, irq}, {31'd0, IRQ_EN});

    // Pin held high through reset release
    in_port = 4'b1000;
    wait_cycles(2);
    #2 reset_n = 1'b0;
    wait_cycles(3);
    #2 reset_n = 1'b1;
    wait_cycles(6);
    bus_read(ADDR_EDGE, rd);
    check("held_high_no_edge", rd, 32'h0);
    bus_read(ADDR_DATA, rd);
    check("data_1000", rd, 32'h0000_0008);
    check("held_irq0", {31'd0, irq}, 32'h0);
    in_port = 4'b0000;
    wait_cycles(3);
    in_port = 4'b1000;
    wait_cycles(5);
    bus_read(ADDR_EDGE, rd);
    check("toggle_sets_bit3", rd, 32'h0000_0008 & EN_MASK);
    bus_read(ADDR_RSVD, rd);
    check("reserved_zero", rd, 32'h0);

    // Randomized traffic, with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) in_port = 4'($urandom_range(0, 15));
      chipselect = 1'($urandom_range(0, 1));
      read_n     = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      if (i == 1500) #2 reset_n = 1'b0;
      if (i == 1503) #2 reset_n = 1'b1;
      @(negedge clk);
    end
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    wait_cycles(2);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
